// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, tick-based debouncer and event pulse generator
//
// Ports:
//   CLK      system clock, all logic on its rising edge
//   RST      asynchronous active-low reset
//   BTN      raw button pins, asynchronous to CLK, 1 = pressed
//   LEVEL    debounced button state, registered
//   PRESS    one-cycle pulse when a press is accepted (and on each auto-repeat)
//   RELEASE  one-cycle pulse when a release is accepted
//
// Optional feature: define BTN_REPEAT_EN to build the per-button auto-repeat
// logic (REPEAT_DLY ticks to the first repeat, then every REPEAT_PER ticks).

module btn_debounce #(
    parameter int NBTN       = 4,
    parameter int PRESCALE_W = 17,
    parameter int STABLE_CNT = 8,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NBTN-1:0] BTN,
    output logic [NBTN-1:0] LEVEL,
    output logic [NBTN-1:0] PRESS,
    output logic [NBTN-1:0] RELEASE
);

    localparam logic [7:0] SCNT_LAST = 8'(STABLE_CNT - 1);

    // Elaboration-time parameter sanity checks.
    if (STABLE_CNT < 2 || STABLE_CNT > 255) begin : g_bad_stable_cnt
        $error("btn_debounce: STABLE_CNT out of range 2..255");
    end
    if (REPEAT_PER < 1 || REPEAT_PER > REPEAT_DLY || REPEAT_DLY > 1023) begin : g_bad_repeat
        $error("btn_debounce: REPEAT_DLY/REPEAT_PER out of range");
    end

    logic [NBTN-1:0]       sync1;
    logic [NBTN-1:0]       bsync;
    logic [PRESCALE_W-1:0] presc;
    logic                  tick;
    logic [7:0]            scnt [NBTN];
    logic [NBTN-1:0]       accept;
    logic [NBTN-1:0]       rep_hit;

    // Two-flop synchroniser; bsync lags BTN by two clocks.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= '0;
            bsync <= '0;
        end else begin
            sync1 <= BTN;
            bsync <= sync1;
        end
    end

    // Free-running prescaler; the all-ones cycle is the sample tick.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = &presc;

    // A new value is accepted on the tick that completes STABLE_CNT
    // consecutive disagreeing samples.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NBTN; i++) begin
            accept[i] = tick && (bsync[i] != LEVEL[i]) && (scnt[i] == SCNT_LAST);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NBTN; i++) begin
                scnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < NBTN; i++) begin
                // Any tick that agrees with LEVEL restarts the count.
                if (bsync[i] == LEVEL[i] || accept[i]) begin
                    scnt[i] <= '0;
                end else begin
                    scnt[i] <= scnt[i] + 8'd1;
                end
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam logic [9:0] RDLY    = 10'(REPEAT_DLY);
    localparam logic [9:0] RRELOAD = 10'(REPEAT_DLY - REPEAT_PER);

    logic [9:0] rcnt [NBTN];

    // A repeat fires on the tick that brings rcnt up to REPEAT_DLY, but never
    // on a tick that accepts a release (accept with LEVEL=1).
    always_comb begin
        rep_hit = '0;
        for (int i = 0; i < NBTN; i++) begin
            rep_hit[i] = tick && LEVEL[i] && !accept[i] && ((rcnt[i] + 10'd1) == RDLY);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NBTN; i++) begin
                rcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (!LEVEL[i] || accept[i]) begin
                    rcnt[i] <= '0;
                end else if (tick) begin
                    // Reloading DLY-PER makes later repeats PER ticks apart.
                    rcnt[i] <= rep_hit[i] ? RRELOAD : rcnt[i] + 10'd1;
                end
            end
        end
    end
`else
    assign rep_hit = '0;
`endif

    // LEVEL and the event pulses are registered together so a pulse always
    // coincides with the LEVEL edge it reports.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            LEVEL   <= '0;
            PRESS   <= '0;
            RELEASE <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (accept[i]) begin
                    LEVEL[i] <= bsync[i];
                end
                PRESS[i]   <= (accept[i] && bsync[i]) || rep_hit[i];
                RELEASE[i] <= accept[i] && !bsync[i];
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - randomized self-checking bench for btn_debounce against a tick-history model

module tb_btn_debounce;

    localparam int NBTN   = 4;
    localparam int PW     = 2;
    localparam int STABLE = 3;
    localparam int RDLY   = 5;
    localparam int RPER   = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [NBTN-1:0] BTN = '0;
    logic [NBTN-1:0] LEVEL, PRESS, RELEASE;

    btn_debounce #(
        .NBTN(NBTN), .PRESCALE_W(PW), .STABLE_CNT(STABLE),
        .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)
    ) dut (
        .CLK(CLK), .RST(RST), .BTN(BTN),
        .LEVEL(LEVEL), .PRESS(PRESS), .RELEASE(RELEASE)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: BTN samples seen at each clock edge, the synchronised
    // value sampled on each tick, and per button the tick index where its
    // current level was accepted.
    int              k;
    logic [NBTN-1:0] bh [$];
    logic [NBTN-1:0] th [$];
    int              acc_idx [NBTN];
    logic [NBTN-1:0] m_level, m_press, m_rel;

    task automatic model_reset();
        k = 0;
        bh.delete();
        th.delete();
        for (int i = 0; i < NBTN; i++) acc_idx[i] = 0;
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
    endtask

    task automatic model_edge(input logic [NBTN-1:0] b, input logic rst_now);
        logic [NBTN-1:0] bs;
        int n, run, held;
        m_press = '0;
        m_rel   = '0;
        if (!rst_now) begin
            model_reset();
            return;
        end
        k++;
        bs = (bh.size() >= 2) ? bh[bh.size()-2] : '0;
        bh.push_back(b);
        if (bh.size() > 4) void'(bh.pop_front());
        if (k % (1 << PW) == 0) begin
            th.push_back(bs);
            n = th.size();
            for (int i = 0; i < NBTN; i++) begin
                run = 0;
                for (int j = n - 1; j >= acc_idx[i]; j--) begin
                    if (th[j][i] != m_level[i]) run++;
                    else break;
                end
                if (run >= STABLE) begin
                    m_level[i] = bs[i];
                    if (bs[i]) m_press[i] = 1'b1;
                    else       m_rel[i]   = 1'b1;
                    acc_idx[i] = n;
                end
`ifdef BTN_REPEAT_EN
                else if (m_level[i]) begin
                    held = n - acc_idx[i];
                    if (held >= RDLY && (held - RDLY) % RPER == 0) m_press[i] = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge(BTN, RST);
        #1;
        check("level",   LEVEL,   m_level);
        check("press",   PRESS,   m_press);
        check("release", RELEASE, m_rel);
        check("excl",    PRESS & RELEASE, '0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit found;
        model_reset();

        // Reset with all buttons pressed.
        RST = 1'b0;
        BTN = 4'b1111;
        steps(4);
        check("rst_level", LEVEL, 4'b0000);
        check("rst_press", PRESS, 4'b0000);
        check("rst_rel",   RELEASE, 4'b0000);
        BTN = '0;
        RST = 1'b1;
        steps(100);
        check("idle_level", LEVEL, 4'b0000);

        // Clean press on bit 0.
        BTN[0] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 15 && !found; c++) begin
            step();
            if (LEVEL[0]) begin
                found = 1'b1;
                check("press_pulse", PRESS, 4'b0001);
            end
        end
        check("press_latency", found, 1'b1);
        step();
        check("press_one_clk", PRESS, 4'b0000);
        steps(4);

        // Bounce on bit 1.
        for (int c = 0; c < 40; c++) begin
            BTN[1] = ((c / 3) % 2) == 0;
            step();
            check("bounce_lvl1", LEVEL[1], 1'b0);
        end
        BTN[1] = 1'b0;
        steps(20);

        // Simultaneous release of bit 0 and press of bit 2.
        BTN[0] = 1'b0;
        BTN[2] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 16 && !found; c++) begin
            step();
            if (RELEASE[0] || PRESS[2]) begin
                found = 1'b1;
                check("simul_rel", RELEASE, 4'b0001);
                check("simul_prs", PRESS[2], 1'b1);
            end
        end
        check("simul_seen", found, 1'b1);
        steps(3);
        check("simul_level", LEVEL, 4'b0100);
        BTN[2] = 1'b0;
        steps(20);

        // Reset mid-count with bit 3 held.
        BTN[3] = 1'b1;
        steps(8);
        RST = 1'b0;
        #1;
        check("async_rst", {LEVEL, PRESS, RELEASE}, 12'h000);
        steps(2);
        RST = 1'b1;
        steps(20);
        check("rearm_level", LEVEL[3], 1'b1);
        BTN[3] = 1'b0;
        steps(20);

        // Long hold on bit 0 (auto-repeat when built in).
        BTN[0] = 1'b1;
        steps(120);
        BTN[0] = 1'b0;
        steps(30);

        // Randomized traffic: slow flips, bursts of bounce, rare resets.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NBTN; i++) begin
                if ($urandom_range(0, 19) == 0) BTN[i] = ~BTN[i];
            end
            if ($urandom_range(0, 99) == 0) BTN = BTN ^ 4'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                RST = 1'b0;
                steps($urandom_range(1, 3));
                RST = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-side counterpart to the LED output path: reads the PYNQ push buttons and turns them into clean, registered button states and one-cycle event pulses.
- Each raw button is synchronised, then debounced on a slow sample tick taken from a free-running prescaler.
- Its outputs feed the LED and mode-control logic directly.

Parameters:
- NBTN, 4: number of button inputs.
- PRESCALE_W, 17: prescaler width. Sample tick period is 2^PRESCALE_W clocks (about 1.05 ms at 125 MHz).
- STABLE_CNT, 8: number of consecutive ticks a new value must hold before it is accepted. Legal range 2..255.
- REPEAT_DLY, 500: ticks from accepted press to first auto-repeat. Used only with BTN_REPEAT_EN.
- REPEAT_PER, 100: ticks between later auto-repeats. Used only with BTN_REPEAT_EN.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  reset, asynchronous, active-low.
- BTN  input  NBTN  raw button pins, asynchronous to CLK, 1 = pressed.
- LEVEL  output  NBTN  debounced button state, registered.
- PRESS  output  NBTN  one-cycle pulse when a press is accepted (and on each auto-repeat, if enabled).
- RELEASE  output  NBTN  one-cycle pulse when a release is accepted.

Behaviour:
- Reset:
  - RST low asynchronously clears the synchroniser flops, prescaler, all per-button counters, LEVEL, PRESS and RELEASE to 0.
  - All buttons are treated as released after reset.
- Synchroniser: two flops per bit. The synchronised value bsync lags BTN by 2 clocks.
- Prescaler:
  - Free-running PRESCALE_W-bit up-counter; wraps from all-ones to 0.
  - tick = 1 in the cycle the counter is all-ones, giving one cycle per 2^PRESCALE_W.
- Per-button debounce, all buttons independent. Counter scnt is 8 bits.
  - On a tick with bsync[i] == LEVEL[i]: scnt[i] <= 0.
  - On a tick with bsync[i] != LEVEL[i] and scnt[i] < STABLE_CNT-1: scnt[i] <= scnt[i]+1.
  - On a tick with bsync[i] != LEVEL[i] and scnt[i] == STABLE_CNT-1: LEVEL[i] <= bsync[i] and scnt[i] <= 0. PRESS[i] <= 1 if bsync[i]=1, otherwise RELEASE[i] <= 1.
  - Non-tick cycles: scnt and LEVEL hold.
  - Activity between ticks is invisible. Any tick that sees the old value restarts the count.
- Pulses:
  - PRESS and RELEASE are registered and high for exactly one clock.
  - They rise in the same cycle LEVEL changes.
  - They are never both high for the same bit.
- Latency: LEVEL changes one clock after the STABLE_CNT-th consecutive tick that sees the new synchronised value.
- Simultaneous events: several bits may change, and pulse, in the same cycle.
- Reset mid-count: the count is lost. A button still held after reset is re-detected as a fresh press after STABLE_CNT ticks, and a PRESS pulse is emitted.

Optional Feature:
- BTN_REPEAT_EN defined:
  - Each button gets a 10-bit repeat counter rcnt, cleared whenever LEVEL[i]=0 and on every accepted press.
  - While LEVEL[i]=1, rcnt increments on each tick.
  - When rcnt reaches REPEAT_DLY, an extra PRESS[i] pulse is emitted and rcnt <= REPEAT_DLY-REPEAT_PER.
  - Result: repeats every REPEAT_PER ticks while the button is held.
  - Release stops repeats immediately. No PRESS is generated in the RELEASE cycle.
- BTN_REPEAT_EN undefined:
  - No repeat logic is built; REPEAT_DLY and REPEAT_PER are ignored.
  - PRESS occurs only on an accepted press.

Test Plan (PRESCALE_W=2, i.e. tick every 4 clocks; STABLE_CNT=3):
- Reset check: hold RST=0 with BTN=4'b1111 -> LEVEL/PRESS/RELEASE = 0. Release reset with BTN=0 for 100 clocks -> outputs stay 0.
- Clean press: BTN[0] 0->1 and held -> LEVEL[0]=1 within 2+3*4+1=15 clocks. PRESS[0] high exactly 1 clock, same cycle as LEVEL[0] rises. Other bits stay 0.
- Bounce rejection: BTN[1] toggles 1/0 every 3 clocks for 40 clocks, then settles at 0 -> LEVEL[1], PRESS[1] and RELEASE[1] stay 0 throughout.
- Release plus simultaneous events: with LEVEL[0]=1, drive BTN[0]=0 and BTN[2]=1 in the same clock -> RELEASE[0] and PRESS[2] pulse in the same cycle. LEVEL becomes 4'b0100.
- Reset mid-operation: BTN[3]=1 held, assert RST after 2 ticks, deassert it -> no PRESS before reset. After 3 fresh ticks, PRESS[3] pulses once and LEVEL[3]=1.
- Repeat (BTN_REPEAT_EN, REPEAT_DLY=5, REPEAT_PER=2): hold BTN[0] -> PRESS[0] at acceptance, again 5 ticks later, then every 2 ticks. Release -> repeats stop and RELEASE[0] pulses once. Rebuild without the macro -> single PRESS only.
